// File: rtl/loopback_pkg.sv
// Shared constants, FSM state type and byte helpers for the UART loopback path.
package loopback_pkg;

  localparam logic [1:0] MODE_ECHO  = 2'd0;
  localparam logic [1:0] MODE_INV   = 2'd1;
  localparam logic [1:0] MODE_CRLF  = 2'd2;
  localparam logic [1:0] MODE_UPPER = 2'd3;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE
  } state_t;

  function automatic logic [7:0] ascii_upper(input logic [7:0] c);
    return (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy flags; read data is the head entry, valid when !empty.
module sync_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              wr_en;
  logic              rd_en;
  logic [CNT_W-1:0]  count_nxt;

  // A push while full is only legal when the head leaves on the same edge.
  assign wr_en   = push && (!full || rd_en);
  assign rd_en   = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({wr_en, rd_en})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == CNT_W'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/loopback_fifo.sv
// Buffered UART echo: RX bytes are queued, optionally transformed at pop, and handed to TX
// under a strobe/busy handshake, with sticky overflow reporting.
module loopback_fifo
  import loopback_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_rx_byte_rdy,
  input  logic [DATA_W-1:0] i_rx_byte,
  input  logic [1:0]        i_mode,
  input  logic              i_tx_busy,
  input  logic              i_clr_ovf,
  output logic              o_tx_byte_rdy,
  output logic [DATA_W-1:0] o_tx_byte,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_overflow
);

  localparam bit IS8 = (DATA_W == 8);

  state_t            state;
  logic              pend_lf;
  logic              pop;
  logic              push;
  logic              ovf_evt;
  logic [DATA_W-1:0] rd_data;
  logic [7:0]        rd8;
  logic [DATA_W-1:0] tx_next;
  logic              lf_next;

  assign pop     = (state == IDLE) && !pend_lf && !o_empty && !i_tx_busy;
  assign push    = i_rx_byte_rdy && (!o_full || pop);
  assign ovf_evt = i_rx_byte_rdy && o_full && !pop;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .push    (push),
    .wr_data (i_rx_byte),
    .pop     (pop),
    .rd_data (rd_data),
    .count   (o_count),
    .full    (o_full),
    .empty   (o_empty)
  );

  // Text modes only make sense on 8-bit characters; other widths fall back to plain echo.
  always_comb begin
    rd8     = 8'(rd_data);
    tx_next = rd_data;
    lf_next = 1'b0;
    case (i_mode)
      MODE_INV:   tx_next = ~rd_data;
      MODE_CRLF:  lf_next = IS8 && (rd8 == ASCII_CR);
      MODE_UPPER: if (IS8) tx_next = DATA_W'(ascii_upper(rd8));
      default:    tx_next = rd_data;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      pend_lf       <= 1'b0;
      o_tx_byte_rdy <= 1'b0;
      o_tx_byte     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pend_lf) begin
            o_tx_byte     <= DATA_W'(ASCII_LF);
            pend_lf       <= 1'b0;
            o_tx_byte_rdy <= 1'b1;
            state         <= ISSUE;
          end else if (pop) begin
            o_tx_byte     <= tx_next;
            pend_lf       <= lf_next;
            o_tx_byte_rdy <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          o_tx_byte_rdy <= 1'b0;
          state         <= WAIT_ACK;
        end
        WAIT_ACK:  if (i_tx_busy)  state <= WAIT_DONE;
        WAIT_DONE: if (!i_tx_busy) state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)       o_overflow <= 1'b0;
    else if (ovf_evt)   o_overflow <= 1'b1;
    else if (i_clr_ovf) o_overflow <= 1'b0;
  end

endmodule

// File: tb/tb_loopback_fifo.sv
// Directed bench for loopback_fifo with a behavioural TX serialiser that answers each strobe.
module tb_loopback_fifo;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned CNT_W  = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              rx_rdy;
  logic [DATA_W-1:0] rx_byte;
  logic [1:0]        mode;
  logic              tx_busy;
  logic              clr_ovf;
  logic              tx_rdy;
  logic [DATA_W-1:0] tx_byte;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              overflow;

  logic              tx_hold;
  logic              mdl_busy;
  int unsigned       mdl_cnt;
  int unsigned       busy_len;
  logic [7:0]        cap[$];
  logic [7:0]        exp_q[$];
  int unsigned       max_cnt;
  logic              full_seen;

  int n_chk = 0;
  int n_bad = 0;

  assign tx_busy = tx_hold | mdl_busy;

  always #5 clk = ~clk;

  loopback_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_rx_byte_rdy (rx_rdy),
    .i_rx_byte     (rx_byte),
    .i_mode        (mode),
    .i_tx_busy     (tx_busy),
    .i_clr_ovf     (clr_ovf),
    .o_tx_byte_rdy (tx_rdy),
    .o_tx_byte     (tx_byte),
    .o_count       (count),
    .o_full        (full),
    .o_empty       (empty),
    .o_overflow    (overflow)
  );

  // TX model: busy rises the cycle after a strobe and stays high for busy_len cycles.
  always @(negedge clk) begin
    if (!rst_n) begin
      mdl_cnt  = 0;
      mdl_busy = 1'b0;
    end else begin
      if (32'(count) > max_cnt) max_cnt = 32'(count);
      if (full) full_seen = 1'b1;
      if (tx_rdy) begin
        cap.push_back(tx_byte);
        mdl_cnt = busy_len + 1;
      end else if (mdl_cnt > 0) begin
        mdl_cnt  = mdl_cnt - 1;
        mdl_busy = (mdl_cnt > 0);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_rdy  = 1'b1;
    rx_byte = b;
    @(negedge clk);
    rx_rdy  = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int waited = 0;
    while (cap.size() < exp_q.size() && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    repeat (30) @(negedge clk);
    chk({tag, "_n"}, cap.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++)
      chk($sformatf("%s_%0d", tag, i), cap[i], exp_q[i]);
    cap.delete();
    exp_q.delete();
  endtask

  initial begin
    rst_n = 1'b0; rx_rdy = 1'b0; rx_byte = '0; mode = 2'd0; clr_ovf = 1'b0;
    tx_hold = 1'b0; mdl_busy = 1'b0; mdl_cnt = 0; busy_len = 10;
    max_cnt = 0; full_seen = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rdy", tx_rdy, 0);
    chk("rst_byte", tx_byte, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single byte: strobe must appear two cycles after the RX strobe.
    send(8'h41);
    chk("lat_n1", tx_rdy, 0);
    @(negedge clk);
    chk("lat_n2", tx_rdy, 1);
    chk("lat_byte", tx_byte, 8'h41);
    @(negedge clk);
    chk("lat_once", tx_rdy, 0);
    exp_q.push_back(8'h41);
    drain("single", 100);

    // Burst: byte 0 pops at once, 1..16 fill the FIFO, 17..19 are dropped.
    busy_len = 20;
    max_cnt = 0; full_seen = 1'b0;
    for (int k = 0; k < 20; k++) send(8'(k));
    chk("burst_ovf", overflow, 1);
    chk("burst_cnt", count, 16);
    chk("burst_full_seen", full_seen, 1);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    chk("burst_clr", overflow, 0);
    busy_len = 3;
    for (int k = 0; k <= 16; k++) exp_q.push_back(8'(k));
    drain("burst", 1500);
    chk("burst_max", max_cnt, 16);

    // CR expansion inserts LF ahead of queued data.
    mode = 2'd2;
    send(8'h48); send(8'h0D); send(8'h49);
    exp_q = '{8'h48, 8'h0D, 8'h0A, 8'h49};
    drain("crlf", 300);

    mode = 2'd1;
    send(8'h5A);
    exp_q.push_back(8'hA5);
    drain("inv", 100);

    mode = 2'd3;
    send(8'h61); send(8'h7B); send(8'h41);
    exp_q = '{8'h41, 8'h7B, 8'h41};
    drain("upper", 300);

    // Write and pop on the same edge while full.
    mode = 2'd0;
    tx_hold = 1'b1;
    for (int k = 0; k < 16; k++) send(8'h80 + 8'(k));
    chk("wp_full", full, 1);
    chk("wp_cnt0", count, 16);
    tx_hold = 1'b0;
    send(8'h90);
    chk("wp_cnt", count, 16);
    chk("wp_ovf", overflow, 0);
    for (int k = 0; k <= 16; k++) exp_q.push_back(8'h80 + 8'(k));
    drain("wp", 1500);

    // Reset while waiting for TX to finish, with three bytes still queued.
    busy_len = 10;
    send(8'h31); send(8'h32); send(8'h33); send(8'h34);
    for (int w = 0; w < 50 && !tx_busy; w++) @(negedge clk);
    chk("rst2_busy", tx_busy, 1);
    repeat (2) @(negedge clk);
    chk("rst2_cnt", count, 3);
    rst_n = 1'b0;
    #1;
    chk("rst2_rdy", tx_rdy, 0);
    chk("rst2_byte", tx_byte, 0);
    chk("rst2_count", count, 0);
    chk("rst2_empty", empty, 1);
    chk("rst2_full", full, 0);
    chk("rst2_ovf", overflow, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cap.delete();
    repeat (40) @(negedge clk);
    chk("rst2_nostrobe", cap.size(), 0);
    chk("rst2_empty_after", empty, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
